mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-client line memory arbiter: I-cache and D-cache share one pmem port.
// D-cache is preferred, but a streak limit keeps a waiting I-cache from starving.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int LINE_W       = 256,
    parameter int D_STREAK_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_addr,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_addr,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int SB = $clog2(D_STREAK_MAX + 1);
    localparam int SW = (SB < 2) ? 2 : SB;
    localparam logic [SW-1:0] SMAX = SW'(D_STREAK_MAX);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [SW-1:0]     d_streak;
    logic [SW-1:0]     d_streak_nx;
    logic [ADDR_W-1:0] h_addr;
    logic [ADDR_W-1:0] h_addr_nx;
    logic [LINE_W-1:0] h_wdata;
    logic [LINE_W-1:0] h_wdata_nx;
    logic              h_read;
    logic              h_read_nx;
    logic              h_write;
    logic              h_write_nx;

    logic i_req;
    logic d_req;
    logic streak_full;
    logic grant_d;
    logic grant_i;

    assign i_req       = i_pmem_read;
    assign d_req       = d_pmem_read | d_pmem_write;
    assign streak_full = (d_streak == SMAX);
    assign grant_d     = d_req & (~i_req | ~streak_full);
    assign grant_i     = i_req & ~grant_d;

    // pmem side is driven purely from the holding registers
    assign pmem_read  = h_read;
    assign pmem_write = h_write;
    assign pmem_addr  = h_addr;
    assign pmem_wdata = h_wdata;

    // State, streak counter and holding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            d_streak <= '0;
            h_addr   <= '0;
            h_wdata  <= '0;
            h_read   <= 1'b0;
            h_write  <= 1'b0;
        end else begin
            state    <= state_nx;
            d_streak <= d_streak_nx;
            h_addr   <= h_addr_nx;
            h_wdata  <= h_wdata_nx;
            h_read   <= h_read_nx;
            h_write  <= h_write_nx;
        end
    end

    // Grant decision, capture and completion routing
    always_comb begin
        state_nx     = state;
        d_streak_nx  = d_streak;
        h_addr_nx    = h_addr;
        h_wdata_nx   = h_wdata;
        h_read_nx    = h_read;
        h_write_nx   = h_write;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        i_pmem_rdata = '0;
        d_pmem_rdata = '0;
        unique case (state)
            IDLE: begin
                h_read_nx  = 1'b0;
                h_write_nx = 1'b0;
                if (grant_d) begin
                    state_nx   = SERVE_D;
                    h_addr_nx  = d_pmem_addr;
                    h_wdata_nx = d_pmem_wdata;
                    // a simultaneous read+write is treated as the writeback
                    h_write_nx = d_pmem_write;
                    h_read_nx  = ~d_pmem_write;
                    if (!i_req) begin
                        d_streak_nx = '0;
                    end else if (!streak_full) begin
                        d_streak_nx = d_streak + 1'b1;
                    end
                end else if (grant_i) begin
                    state_nx    = SERVE_I;
                    h_addr_nx   = i_pmem_addr;
                    h_wdata_nx  = '0;
                    h_read_nx   = 1'b1;
                    d_streak_nx = '0;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    i_pmem_resp  = 1'b1;
                    i_pmem_rdata = pmem_rdata;
                    h_read_nx    = 1'b0;
                    h_write_nx   = 1'b0;
                    state_nx     = IDLE;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    d_pmem_resp  = 1'b1;
                    d_pmem_rdata = pmem_rdata;
                    h_read_nx    = 1'b0;
                    h_write_nx   = 1'b0;
                    state_nx     = IDLE;
                end
            end
            default: begin
                state_nx   = IDLE;
                h_read_nx  = 1'b0;
                h_write_nx = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus
// hand-written reset sequences.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_addr;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_addr;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_addr;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int n_vec;
    int n_miss;

    mem_arbiter #(
        .ADDR_W(AW),
        .LINE_W(LW),
        .D_STREAK_MAX(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_pmem_read(i_pmem_read),
        .i_pmem_addr(i_pmem_addr),
        .i_pmem_rdata(i_pmem_rdata),
        .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read),
        .d_pmem_write(d_pmem_write),
        .d_pmem_addr(d_pmem_addr),
        .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata),
        .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read),
        .pmem_write(pmem_write),
        .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          ir;
        logic [AW-1:0] ia;
        logic          dr;
        logic          dw;
        logic [AW-1:0] da;
        logic [7:0]    dwd;
        logic          pr;
        logic [7:0]    prd;
        logic          epr;
        logic          epw;
        logic [AW-1:0] ea;
        logic [7:0]    ewd;
        logic          eir;
        logic [7:0]    eird;
        logic          edr;
        logic [7:0]    edrd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic ir, input logic [AW-1:0] ia,
        input logic dr, input logic dw,
        input logic [AW-1:0] da, input logic [7:0] dwd,
        input logic pr, input logic [7:0] prd,
        input logic epr, input logic epw,
        input logic [AW-1:0] ea, input logic [7:0] ewd,
        input logic eir, input logic [7:0] eird,
        input logic edr, input logic [7:0] edrd
    );
        vec_t v;
        v.ir = ir;   v.ia = ia;
        v.dr = dr;   v.dw = dw;
        v.da = da;   v.dwd = dwd;
        v.pr = pr;   v.prd = prd;
        v.epr = epr; v.epw = epw;
        v.ea = ea;   v.ewd = ewd;
        v.eir = eir; v.eird = eird;
        v.edr = edr; v.edrd = edrd;
        return v;
    endfunction

    function automatic logic [LW-1:0] line(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic chk(input string nm,
                       input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_pmem_read  = 1'b0;
        i_pmem_addr  = '0;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        d_pmem_addr  = '0;
        d_pmem_wdata = '0;
        pmem_resp    = 1'b0;
        pmem_rdata   = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " pmem_read"},  LW'(pmem_read),   '0);
        chk({tag, " pmem_write"}, LW'(pmem_write),  '0);
        chk({tag, " i_resp"},     LW'(i_pmem_resp), '0);
        chk({tag, " d_resp"},     LW'(d_pmem_resp), '0);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        idle_inputs();
        rst = 1'b1;

        // lone I read 0x60, served over five cycles
        tbl.push_back(mk(0,0,     0,0,0,0,     0,0,    0,0,0,0,     0,0,    0,0));
        tbl.push_back(mk(1,'h60,  0,0,0,0,     0,0,    0,0,0,0,     0,0,    0,0));
        tbl.push_back(mk(1,'h60,  0,0,0,0,     0,0,    1,0,'h60,0,  0,0,    0,0));
        tbl.push_back(mk(1,'h60,  0,0,0,0,     0,0,    1,0,'h60,0,  0,0,    0,0));
        tbl.push_back(mk(1,'h60,  0,0,0,0,     0,0,    1,0,'h60,0,  0,0,    0,0));
        tbl.push_back(mk(1,'h60,  0,0,0,0,     0,0,    1,0,'h60,0,  0,0,    0,0));
        tbl.push_back(mk(1,'h60,  0,0,0,0,     1,'hAB, 1,0,'h60,0,  1,'hAB, 0,0));
        tbl.push_back(mk(0,0,     0,0,0,0,     0,0,    0,0,0,0,     0,0,    0,0));
        // simultaneous I read 0x100 and D write 0x200: D first
        tbl.push_back(mk(1,'h100, 0,1,'h200,'h5A, 0,0, 0,0,0,0,     0,0,    0,0));
        tbl.push_back(mk(1,'h100, 0,1,'h200,'h5A, 1,'h11, 0,1,'h200,'h5A, 0,0, 1,'h11));
        tbl.push_back(mk(1,'h100, 0,0,0,0,     0,0,    0,0,0,0,     0,0,    0,0));
        tbl.push_back(mk(1,'h100, 0,0,0,0,     1,'h22, 1,0,'h100,0, 1,'h22, 0,0));
        tbl.push_back(mk(0,0,     0,0,0,0,     0,0,    0,0,0,0,     0,0,    0,0));
        // I waits while D re-requests: D,D,D,I then D
        tbl.push_back(mk(1,'h140, 1,0,'h500,0, 0,0,    0,0,0,0,     0,0,    0,0));
        tbl.push_back(mk(1,'h140, 1,0,'h500,0, 1,'h33, 1,0,'h500,0, 0,0,    1,'h33));
        tbl.push_back(mk(1,'h140, 1,0,'h500,0, 0,0,    0,0,0,0,     0,0,    0,0));
        tbl.push_back(mk(1,'h140, 1,0,'h500,0, 1,'h33, 1,0,'h500,0, 0,0,    1,'h33));
        tbl.push_back(mk(1,'h140, 1,0,'h500,0, 0,0,    0,0,0,0,     0,0,    0,0));
        tbl.push_back(mk(1,'h140, 1,0,'h500,0, 1,'h33, 1,0,'h500,0, 0,0,    1,'h33));
        tbl.push_back(mk(1,'h140, 1,0,'h500,0, 0,0,    0,0,0,0,     0,0,    0,0));
        tbl.push_back(mk(1,'h140, 1,0,'h500,0, 1,'h44, 1,0,'h140,0, 1,'h44, 0,0));
        tbl.push_back(mk(0,0,     1,0,'h500,0, 0,0,    0,0,0,0,     0,0,    0,0));
        tbl.push_back(mk(0,0,     1,0,'h500,0, 1,'h45, 1,0,'h500,0, 0,0,    1,'h45));
        tbl.push_back(mk(0,0,     0,0,0,0,     0,0,    0,0,0,0,     0,0,    0,0));
        // D address and op change after grant are ignored
        tbl.push_back(mk(0,0,     1,0,'h300,0, 0,0,    0,0,0,0,     0,0,    0,0));
        tbl.push_back(mk(0,0,     1,0,'h400,0, 0,0,    1,0,'h300,0, 0,0,    0,0));
        tbl.push_back(mk(0,0,     0,1,'h400,'hEE, 0,0, 1,0,'h300,0, 0,0,    0,0));
        tbl.push_back(mk(0,0,     0,0,'h400,0, 1,'h55, 1,0,'h300,0, 0,0,    1,'h55));
        tbl.push_back(mk(0,0,     0,0,0,0,     0,0,    0,0,0,0,     0,0,    0,0));
        // D read and write together: write wins
        tbl.push_back(mk(0,0,     1,1,'h600,'h77, 0,0, 0,0,0,0,     0,0,    0,0));
        tbl.push_back(mk(0,0,     1,1,'h600,'h77, 1,'h66, 0,1,'h600,'h77, 0,0, 1,'h66));
        // stray pmem_resp in IDLE
        tbl.push_back(mk(0,0,     0,0,0,0,     1,'h99, 0,0,0,0,     0,0,    0,0));
        tbl.push_back(mk(1,'h80,  0,0,0,0,     0,0,    0,0,0,0,     0,0,    0,0));
        tbl.push_back(mk(1,'h80,  0,0,0,0,     1,'h88, 1,0,'h80,0,  1,'h88, 0,0));
        tbl.push_back(mk(0,0,     0,0,0,0,     0,0,    0,0,0,0,     0,0,    0,0));

        // reset state, with no clock edge yet
        i_pmem_read = 1'b1;
        i_pmem_addr = 'h1234;
        pmem_resp   = 1'b1;
        #1;
        chk_quiet("rst0");
        chk("rst0 pmem_addr", LW'(pmem_addr), '0);
        chk("rst0 pmem_wdata", pmem_wdata, '0);
        chk("rst0 i_rdata", i_pmem_rdata, '0);
        idle_inputs();
        #2;
        rst = 1'b0;

        foreach (tbl[k]) begin
            @(posedge clk);
            #1;
            i_pmem_read  = tbl[k].ir;
            i_pmem_addr  = tbl[k].ia;
            d_pmem_read  = tbl[k].dr;
            d_pmem_write = tbl[k].dw;
            d_pmem_addr  = tbl[k].da;
            d_pmem_wdata = line(tbl[k].dwd);
            pmem_resp    = tbl[k].pr;
            pmem_rdata   = line(tbl[k].prd);
            @(negedge clk);
            chk($sformatf("v%0d pmem_read", k),
                LW'(pmem_read), LW'(tbl[k].epr));
            chk($sformatf("v%0d pmem_write", k),
                LW'(pmem_write), LW'(tbl[k].epw));
            chk($sformatf("v%0d i_resp", k),
                LW'(i_pmem_resp), LW'(tbl[k].eir));
            chk($sformatf("v%0d d_resp", k),
                LW'(d_pmem_resp), LW'(tbl[k].edr));
            chk($sformatf("v%0d i_rdata", k),
                i_pmem_rdata, line(tbl[k].eird));
            chk($sformatf("v%0d d_rdata", k),
                d_pmem_rdata, line(tbl[k].edrd));
            if (tbl[k].epr || tbl[k].epw)
                chk($sformatf("v%0d pmem_addr", k),
                    LW'(pmem_addr), LW'(tbl[k].ea));
            if (tbl[k].epw)
                chk($sformatf("v%0d pmem_wdata", k),
                    pmem_wdata, line(tbl[k].ewd));
        end

        // asynchronous reset in the middle of SERVE_I
        @(posedge clk);
        #1;
        idle_inputs();
        i_pmem_read = 1'b1;
        i_pmem_addr = 'hA0;
        @(posedge clk);
        #1;
        chk("ar serve pmem_read", LW'(pmem_read), 1);
        chk("ar serve pmem_addr", LW'(pmem_addr), 'hA0);
        @(negedge clk);
        #1;
        pmem_resp  = 1'b1;
        pmem_rdata = line(8'hCD);
        rst = 1'b1;
        #1;
        chk_quiet("ar mid");
        chk("ar mid i_rdata", i_pmem_rdata, '0);
        chk("ar mid pmem_addr", LW'(pmem_addr), '0);
        i_pmem_read = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        @(negedge clk);
        chk_quiet("ar post");
        // new request after reset is granted from IDLE normally
        #1;
        i_pmem_read = 1'b1;
        i_pmem_addr = 'hC0;
        @(negedge clk);
        chk("ar idle pmem_read", LW'(pmem_read), 1);
        chk("ar idle pmem_addr", LW'(pmem_addr), 'hC0);
        #1;
        pmem_resp  = 1'b1;
        pmem_rdata = line(8'h3C);
        #1;
        chk("ar resp i_resp", LW'(i_pmem_resp), 1);
        chk("ar resp i_rdata", i_pmem_rdata, line(8'h3C));
        chk("ar resp d_resp", LW'(d_pmem_resp), 0);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        chk_quiet("ar end");

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
